// File: rtl/dff_bist_pkg.sv
// dff_bist_pkg: shared types and helpers for the DFF BIST controller.
//   bist_state_t : controller FSM states
//   LFSR_TAPS    : feedback tap mask for x^8+x^6+x^5+x^4+1, right-shifting
//   lfsr_step()  : one step of the 8-bit Fibonacci LFSR
package dff_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } bist_state_t;

  // Shifting right, polynomial exponent k maps to state bit 8-k: bits 0,2,3,4.
  localparam logic [7:0] LFSR_TAPS = 8'b0001_1101;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {^(s & LFSR_TAPS), s[7:1]};
  endfunction

endpackage

// File: rtl/dff_bist_lfsr.sv
// dff_bist_lfsr: 8-bit Fibonacci LFSR pattern source with load and enable.
//   clk     : clock
//   rst_n   : synchronous active-low reset (state <= SEED)
//   load    : reload SEED (has priority over en)
//   en      : advance one step
//   out_bit : current state bit 0, the bit to drive this step
module dff_bist_lfsr
  import dff_bist_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic out_bit
);

  logic [7:0] state;

  always_ff @(posedge clk) begin
    if (!rst_n)    state <= SEED;
    else if (load) state <= SEED;
    else if (en)   state <= lfsr_step(state);
  end

  assign out_bit = state[0];

endmodule

// File: rtl/dff_bist_ctrl.sv
// dff_bist_ctrl: BIST sequencer for a single D flip-flop.
// On start it holds the DFF in reset for RST_CYC cycles and checks the cleared
// state, then drives len LFSR bits and checks each one a cycle later, with a
// final DRAIN check. Reports a saturating mismatch count and a pass flag.
//   clk, i_rst_n          : clock, synchronous active-low controller reset
//   i_start, i_len        : start request (IDLE only), run length captured at start
//   o_dut_rst_n, o_dut_din: drive the DFF reset and data inputs
//   i_dut_dout(_n)        : DFF outputs under test
//   o_busy, o_done        : busy in RST/RUN/DRAIN, one-cycle done pulse
//   o_pass, o_err_cnt     : result, held until the next start
module dff_bist_ctrl
  import dff_bist_pkg::*;
#(
  parameter int         LEN_W   = 10,
  parameter int         ERR_W   = 8,
  parameter int         RST_CYC = 2,
  parameter logic [7:0] SEED    = 8'hA5
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_dut_rst_n,
  output logic             o_dut_din,
  input  logic             i_dut_dout,
  input  logic             i_dut_dout_n,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [3:0]       RST_LAST = 4'(RST_CYC - 1);

  bist_state_t      state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] run_cnt;
  logic [3:0]       rst_cnt;
  logic             last_din;   // bit driven in the previous cycle = expected dout now

  logic             rst_last, run_last;
  logic             lfsr_load, lfsr_en, lfsr_bit;
  logic             chk_en, chk_ok;
  logic [ERR_W-1:0] err_nxt;

  assign rst_last = (rst_cnt == RST_LAST);
  assign run_last = (run_cnt == len_q - LEN_W'(1));

  // Load on accepted start; step whenever the next cycle is a RUN cycle,
  // since that edge registers the current bit 0 onto o_dut_din.
  assign lfsr_load = (state == ST_IDLE) && i_start;
  assign lfsr_en   = ((state == ST_RST) && rst_last && (len_q != '0)) ||
                     ((state == ST_RUN) && !run_last);

  dff_bist_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (i_rst_n),
    .load    (lfsr_load),
    .en      (lfsr_en),
    .out_bit (lfsr_bit)
  );

  // Checks: last RST cycle (cleared state), RUN cycles after the first, DRAIN.
  always_comb begin
    chk_en = 1'b0;
    chk_ok = 1'b1;
    case (state)
      ST_RST: begin
        chk_en = rst_last;
        chk_ok = (i_dut_dout == 1'b0) && (i_dut_dout_n == 1'b1);
      end
      ST_RUN, ST_DRAIN: begin
        chk_en = (state == ST_DRAIN) || (run_cnt != '0);
        chk_ok = (i_dut_dout == last_din) && (i_dut_dout_n == !last_din);
      end
      default: ;
    endcase
  end

  // X on the DFF outputs makes chk_ok unknown, which falls into the error branch.
  always_comb begin
    err_nxt = o_err_cnt;
    if (chk_en) begin
      if (chk_ok) err_nxt = o_err_cnt;
      else if (o_err_cnt != ERR_MAX) err_nxt = o_err_cnt + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      run_cnt     <= '0;
      rst_cnt     <= '0;
      last_din    <= 1'b0;
      o_dut_rst_n <= 1'b0;
      o_dut_din   <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_err_cnt   <= '0;
    end else begin
      last_din  <= o_dut_din;
      o_err_cnt <= err_nxt;
      o_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_dut_rst_n <= 1'b1;
          o_dut_din   <= 1'b0;
          if (i_start) begin
            state       <= ST_RST;
            len_q       <= i_len;
            rst_cnt     <= '0;
            o_err_cnt   <= '0;
            o_pass      <= 1'b0;
            o_busy      <= 1'b1;
            o_dut_rst_n <= 1'b0;
          end
        end
        ST_RST: begin
          if (!rst_last) begin
            rst_cnt <= rst_cnt + 4'd1;
          end else if (len_q == '0) begin
            state       <= ST_DONE;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
            o_pass      <= (err_nxt == '0);
            o_dut_rst_n <= 1'b1;
          end else begin
            state       <= ST_RUN;
            run_cnt     <= '0;
            o_dut_rst_n <= 1'b1;
            o_dut_din   <= lfsr_bit;
          end
        end
        ST_RUN: begin
          if (run_last) begin
            state     <= ST_DRAIN;
            o_dut_din <= 1'b0;
          end else begin
            run_cnt   <= run_cnt + LEN_W'(1);
            o_dut_din <= lfsr_bit;
          end
        end
        ST_DRAIN: begin
          state  <= ST_DONE;
          o_busy <= 1'b0;
          o_done <= 1'b1;
          o_pass <= (err_nxt == '0);
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bist_ctrl.sv
// tb_dff_bist_ctrl: self-checking bench for dff_bist_ctrl with a behavioural
// DFF (good, dout stuck-at-1, or dout_n tied to dout) and a reference model
// that derives the LFSR bit stream from its linear recurrence.
module tb_dff_bist_ctrl;

  localparam int R = 2;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [9:0] len;
  logic       dut_rst_n, din, dout, dout_n;
  logic       busy, done, pass;
  logic [7:0] err_cnt;

  int   fault = 0;   // 0 good, 1 dout stuck at 1, 2 dout_n tied to dout
  logic q;

  int n_pass = 0, n_tot = 0;
  bit bits [0:511];

  // Observations of one run
  int o_done_cyc, o_err, o_pass, o_din_bad, o_rst_bad, o_busy_bad;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!dut_rst_n) q <= 1'b0;
    else            q <= din;
  end
  assign dout   = (fault == 1) ? 1'b1 : q;
  assign dout_n = (fault == 2) ? dout : ~q;

  dff_bist_ctrl #(.LEN_W(10), .ERR_W(8), .RST_CYC(R), .SEED(8'hA5)) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_len        (len),
    .o_dut_rst_n  (dut_rst_n),
    .o_dut_din    (din),
    .i_dut_dout   (dout),
    .i_dut_dout_n (dout_n),
    .o_busy       (busy),
    .o_done       (done),
    .o_pass       (pass),
    .o_err_cnt    (err_cnt)
  );

  // Bit stream of x^8+x^6+x^5+x^4+1: b[n+8] = b[n]^b[n+2]^b[n+3]^b[n+4],
  // first eight bits are the seed LSB first.
  function automatic void build_bits();
    logic [7:0] s;
    s = 8'hA5;
    for (int i = 0; i < 8; i++) bits[i] = s[i];
    for (int n = 0; n < 504; n++) bits[n+8] = bits[n] ^ bits[n+2] ^ bits[n+3] ^ bits[n+4];
  endfunction

  // Expected error count: each check compares what the faulty DFF shows
  // against the ideal value; count failures, saturate at 255.
  function automatic int exp_errs(input int mode, input int n);
    int e, b, d, dn;
    e  = 0;
    d  = (mode == 1) ? 1 : 0;
    dn = (mode == 2) ? d : 1;
    if (d != 0 || dn != 1) e++;
    for (int j = 0; j < n; j++) begin
      b  = int'(bits[j]);
      d  = (mode == 1) ? 1 : b;
      dn = (mode == 2) ? d : 1 - b;
      if (d != b || dn != 1 - b) e++;
    end
    return (e > 255) ? 255 : e;
  endfunction

  // Start a run in cycle 0 and observe until the done pulse (bounded).
  // x1/x2: extra cycles in which start is pulsed.
  task automatic run_bist(input int mode, input int n, input int x1, input int x2);
    fault = mode;
    @(negedge clk);
    len   = 10'(n);
    start = 1'b1;
    o_done_cyc = -1; o_err = -1; o_pass = -1;
    o_din_bad = 0; o_rst_bad = 0; o_busy_bad = 0;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      start = (c == x1) || (c == x2);
      if (c <= R) begin
        if (dut_rst_n !== 1'b0 || din !== 1'b0) o_rst_bad++;
      end else if (c <= R + n) begin
        if (din !== bits[c-R-1]) o_din_bad++;
        if (dut_rst_n !== 1'b1) o_rst_bad++;
      end
      if (done === 1'b1) begin
        o_done_cyc = c;
        o_err      = int'(err_cnt);
        o_pass     = int'(pass);
        if (busy !== 1'b0) o_busy_bad++;
        break;
      end else if (busy !== 1'b1) o_busy_bad++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len = '0; fault = 0;
    repeat (3) @(negedge clk);
    n_tot++; if ({dut_rst_n, din, busy, done, pass} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {dut_rst_n, din, busy, done, pass}); else n_pass++;
    n_tot++; if (err_cnt !== 8'd0) $display("FAIL reset_err got %0d want 0", err_cnt); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_tot++; if (dut_rst_n !== 1'b1 || busy !== 1'b0) $display("FAIL idle_out got rst_n=%b busy=%b want 1 0", dut_rst_n, busy); else n_pass++;
  endtask

  task automatic test_good();
    run_bist(0, 16, 0, 0);
    n_tot++; if (o_done_cyc !== 20) $display("FAIL good_done_cyc got %0d want 20", o_done_cyc); else n_pass++;
    n_tot++; if (o_err !== 0 || o_pass !== 1) $display("FAIL good_result got err=%0d pass=%0d want 0 1", o_err, o_pass); else n_pass++;
    n_tot++; if (o_din_bad !== 0) $display("FAIL good_pattern got %0d bad bits want 0", o_din_bad); else n_pass++;
    n_tot++; if (o_rst_bad !== 0 || o_busy_bad !== 0) $display("FAIL good_ctl got rst_bad=%0d busy_bad=%0d want 0 0", o_rst_bad, o_busy_bad); else n_pass++;
    @(negedge clk);
    n_tot++; if (pass !== 1'b1 || err_cnt !== 8'd0 || done !== 1'b0) $display("FAIL good_hold got pass=%b err=%0d done=%b want 1 0 0", pass, err_cnt, done); else n_pass++;
  endtask

  task automatic test_stuck();
    run_bist(1, 0, 0, 0);
    n_tot++; if (o_done_cyc !== 3) $display("FAIL stuck_done_cyc got %0d want 3", o_done_cyc); else n_pass++;
    n_tot++; if (o_err !== 1 || o_pass !== 0) $display("FAIL stuck_result got err=%0d pass=%0d want 1 0", o_err, o_pass); else n_pass++;
    n_tot++; if (o_rst_bad !== 0) $display("FAIL stuck_dut_rst got %0d bad cycles want 0", o_rst_bad); else n_pass++;
  endtask

  task automatic test_complement();
    run_bist(2, 8, 0, 0);
    n_tot++; if (o_err !== 9 || o_pass !== 0) $display("FAIL compl_result got err=%0d pass=%0d want 9 0", o_err, o_pass); else n_pass++;
    n_tot++; if (o_done_cyc !== 12) $display("FAIL compl_done_cyc got %0d want 12", o_done_cyc); else n_pass++;
  endtask

  task automatic test_saturate();
    run_bist(2, 300, 0, 0);
    n_tot++; if (o_err !== 255 || o_pass !== 0) $display("FAIL sat_result got err=%0d pass=%0d want 255 0", o_err, o_pass); else n_pass++;
    n_tot++; if (o_done_cyc !== 304) $display("FAIL sat_done_cyc got %0d want 304", o_done_cyc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_bist(0, 16, 5, 20);
    n_tot++; if (o_done_cyc !== 20 || o_din_bad !== 0) $display("FAIL b2b_first got done=%0d bad=%0d want 20 0", o_done_cyc, o_din_bad); else n_pass++;
    run_bist(0, 16, 0, 0);
    n_tot++; if (o_done_cyc !== 20) $display("FAIL b2b_restart_cyc got %0d want 20", o_done_cyc); else n_pass++;
    n_tot++; if (o_din_bad !== 0 || o_pass !== 1 || o_err !== 0) $display("FAIL b2b_restart got bad=%0d pass=%0d err=%0d want 0 1 0", o_din_bad, o_pass, o_err); else n_pass++;
  endtask

  task automatic test_abort();
    int seen;
    fault = 0;
    @(negedge clk);
    len = 10'd16; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_tot++; if ({busy, dut_rst_n, done, din} !== 4'b0 || err_cnt !== 8'd0) $display("FAIL abort_out got busy=%b rst_n=%b done=%b din=%b err=%0d want 0 0 0 0 0", busy, dut_rst_n, done, din, err_cnt); else n_pass++;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_tot++; if (seen !== 0) $display("FAIL abort_no_done got %0d pulses want 0", seen); else n_pass++;
    run_bist(0, 5, 0, 0);
    n_tot++; if (o_done_cyc !== 9 || o_pass !== 1 || o_err !== 0) $display("FAIL abort_fresh got done=%0d pass=%0d err=%0d want 9 1 0", o_done_cyc, o_pass, o_err); else n_pass++;
  endtask

  task automatic test_random();
    int mode, n, e, dc;
    for (int k = 0; k < 8; k++) begin
      mode = int'($urandom_range(0, 2));
      n    = int'($urandom_range(0, 40));
      e    = exp_errs(mode, n);
      dc   = (n == 0) ? R + 1 : R + n + 2;
      run_bist(mode, n, 0, 0);
      n_tot++; if (o_done_cyc !== dc) $display("FAIL rand%0d_done_cyc mode=%0d len=%0d got %0d want %0d", k, mode, n, o_done_cyc, dc); else n_pass++;
      n_tot++; if (o_err !== e || o_pass !== int'(e == 0)) $display("FAIL rand%0d_result mode=%0d len=%0d got err=%0d pass=%0d want %0d %0d", k, mode, n, o_err, o_pass, e, int'(e == 0)); else n_pass++;
      n_tot++; if (o_din_bad !== 0) $display("FAIL rand%0d_pattern len=%0d got %0d bad bits want 0", k, n, o_din_bad); else n_pass++;
    end
  endtask

  initial begin
    build_bits();
    test_reset();
    test_good();
    test_stuck();
    test_complement();
    test_saturate();
    test_back_to_back();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
